mem_stage: RTL and testbench

Memory-access stage placed directly after the EX-MEM register. It consumes the ALU result, store data and writeback controls of one instruction per cycle. It performs byte/half/word loads and stores over a request/grant/response data-memory port, and stalls upstream while an access is outstanding. It presents a registered, writeback-ready result (value, destination, enable) to the register file.

---
 rtl/mem_stage.sv | 206 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: byte/half/word loads and stores over a req/gnt/rvalid port.
// Ports: EX-MEM inputs (*_i), dmem_* port, stall_o, registered writeback result.
module mem_stage #(
  parameter int WIDTH    = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_i,
  input  logic [ADDR_LEN-1:0] pc_i,
  input  logic [WIDTH-1:0]    alu_out_i,
  input  logic [WIDTH-1:0]    store_data_i,
  input  logic [4:0]          rd_addr_i,
  input  logic                rf_w_en_i,
  input  logic [1:0]          wbsel_i,
  input  logic [1:0]          mem_op_i,
  input  logic [1:0]          mem_size_i,
  input  logic                mem_unsigned_i,
  output logic                stall_o,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  output logic [ADDR_LEN-1:0] dmem_addr_o,
  output logic [3:0]          dmem_be_o,
  output logic [WIDTH-1:0]    dmem_wdata_o,
  input  logic                dmem_gnt_i,
  input  logic                dmem_rvalid_i,
  input  logic [WIDTH-1:0]    dmem_rdata_i,
  output logic                valid_o,
  output logic [WIDTH-1:0]    wb_data_o,
  output logic [4:0]          rd_addr_o,
  output logic                rf_w_en_o,
  output logic                misalign_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]          state;
  logic [ADDR_LEN-1:0] addr_q;
  logic                we_q;
  logic [3:0]          be_q;
  logic [WIDTH-1:0]    wdata_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [1:0]          wbsel_q;
  logic [4:0]          rd_q;
  logic                wen_q;
  logic [ADDR_LEN-1:0] pc4_q;

  logic                accept;
  logic                is_mem;
  logic                is_byte;
  logic                is_half;
  logic                misal;
  logic [ADDR_LEN-1:0] addr_d;
  logic [ADDR_LEN-1:0] pc4_d;
  logic [3:0]          be_d;
  logic [WIDTH-1:0]    wdata_d;
  logic [WIDTH-1:0]    lane;
  logic [WIDTH-1:0]    ext;

  function automatic logic [WIDTH-1:0] wb_mux(
    input logic [1:0]          sel,
    input logic [WIDTH-1:0]    alu,
    input logic [WIDTH-1:0]    mem,
    input logic [ADDR_LEN-1:0] pc4
  );
    logic [WIDTH-1:0] r;
    r = '0;
    unique case (sel)
      2'b00:   r = alu;
      2'b01:   r = mem;
      2'b10:   r = WIDTH'(pc4);
      default: r = '0;
    endcase
    return r;
  endfunction

  assign accept  = valid_i && (state == IDLE);
  assign is_mem  = (mem_op_i == 2'b01) || (mem_op_i == 2'b10);
  assign is_byte = (mem_size_i == 2'b00);
  assign is_half = (mem_size_i == 2'b01);
  assign addr_d  = ADDR_LEN'(alu_out_i);
  assign pc4_d   = pc_i + ADDR_LEN'(4);
  assign misal   = is_mem &&
                   ((is_half && addr_d[0]) ||
                    (!is_byte && !is_half && (addr_d[1:0] != 2'b00)));

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = store_data_i;
    unique case (1'b1)
      is_byte: begin
        be_d    = 4'b0001 << addr_d[1:0];
        wdata_d = {4{store_data_i[7:0]}};
      end
      is_half: begin
        be_d    = 4'b0011 << addr_d[1:0];
        wdata_d = {2{store_data_i[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = store_data_i;
      end
    endcase
  end

  // Requested lane moved down to bit 0, then extended per size.
  assign lane = dmem_rdata_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    ext = lane;
    unique case (size_q)
      2'b00: ext = uns_q ? {24'd0, lane[7:0]}
                         : {{24{lane[7]}}, lane[7:0]};
      2'b01: ext = uns_q ? {16'd0, lane[15:0]}
                         : {{16{lane[15]}}, lane[15:0]};
      default: ext = lane;
    endcase
  end

  assign stall_o      = (state != IDLE);
  assign dmem_req_o   = (state == REQ);
  assign dmem_we_o    = dmem_req_o && we_q;
  assign dmem_addr_o  = dmem_req_o ? {addr_q[ADDR_LEN-1:2], 2'b00} : '0;
  assign dmem_be_o    = dmem_req_o ? be_q : 4'b0000;
  assign dmem_wdata_o = dmem_req_o ? wdata_q : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= 4'b0000;
      wdata_q    <= '0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      wbsel_q    <= 2'b00;
      rd_q       <= 5'd0;
      wen_q      <= 1'b0;
      pc4_q      <= '0;
      valid_o    <= 1'b0;
      wb_data_o  <= '0;
      rd_addr_o  <= 5'd0;
      rf_w_en_o  <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      valid_o    <= 1'b0;
      rf_w_en_o  <= 1'b0;
      misalign_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (is_mem && !misal) begin
              state   <= REQ;
              addr_q  <= addr_d;
              we_q    <= (mem_op_i == 2'b10);
              be_q    <= be_d;
              wdata_q <= wdata_d;
              size_q  <= mem_size_i;
              uns_q   <= mem_unsigned_i;
              wbsel_q <= wbsel_i;
              rd_q    <= rd_addr_i;
              wen_q   <= rf_w_en_i;
              pc4_q   <= pc4_d;
            end else begin
              valid_o   <= 1'b1;
              rd_addr_o <= rd_addr_i;
              if (misal) begin
                misalign_o <= 1'b1;
                wb_data_o  <= '0;
              end else begin
                wb_data_o <= wb_mux(wbsel_i, alu_out_i, '0, pc4_d);
                rf_w_en_o <= rf_w_en_i && (rd_addr_i != 5'd0);
              end
            end
          end
        end
        REQ: begin
          if (dmem_gnt_i) begin
            if (we_q) begin
              state     <= IDLE;
              valid_o   <= 1'b1;
              wb_data_o <= '0;
              rd_addr_o <= rd_q;
            end else begin
              state <= RESP;
            end
          end
        end
        RESP: begin
          if (dmem_rvalid_i) begin
            state     <= IDLE;
            valid_o   <= 1'b1;
            wb_data_o <= wb_mux(wbsel_q, '0, ext, pc4_q);
            rd_addr_o <= rd_q;
            rf_w_en_o <= wen_q && (rd_q != 5'd0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU ops, store, loads, misalign,
// spurious rvalid, back-to-back issue and reset during a load.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic [31:0] alu_out_i = '0;
  logic [31:0] store_data_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        rf_w_en_i = 1'b0;
  logic [1:0]  wbsel_i = '0;
  logic [1:0]  mem_op_i = '0;
  logic [1:0]  mem_size_i = '0;
  logic        mem_unsigned_i = 1'b0;
  logic        stall_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i = 1'b0;
  logic        dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        valid_o;
  logic [31:0] wb_data_o;
  logic [4:0]  rd_addr_o;
  logic        rf_w_en_o;
  logic        misalign_o;

  int n_run = 0;
  int n_fail = 0;

  mem_stage dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .pc_i(pc_i),
    .alu_out_i(alu_out_i), .store_data_i(store_data_i),
    .rd_addr_i(rd_addr_i), .rf_w_en_i(rf_w_en_i),
    .wbsel_i(wbsel_i), .mem_op_i(mem_op_i),
    .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i),
    .stall_o(stall_o), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i(dmem_rdata_i), .valid_o(valid_o),
    .wb_data_o(wb_data_o), .rd_addr_o(rd_addr_o),
    .rf_w_en_o(rf_w_en_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [4:0] rd,
                       input logic wen, input logic [1:0] wbsel,
                       input logic [1:0] op, input logic [1:0] size,
                       input logic uns);
    valid_i = 1'b1;
    pc_i = pc;
    alu_out_i = alu;
    store_data_i = sd;
    rd_addr_i = rd;
    rf_w_en_i = wen;
    wbsel_i = wbsel;
    mem_op_i = op;
    mem_size_i = size;
    mem_unsigned_i = uns;
  endtask

  // Load with minimum latency; a stray rvalid rides along with grant.
  task automatic load(input string tag, input logic [31:0] addr,
                      input logic [1:0] size, input logic uns,
                      input logic [3:0] be, input logic [31:0] exp);
    issue(32'h0, addr, 32'h0, 5'd9, 1'b1, 2'b01, 2'b01, size, uns);
    step();
    valid_i = 1'b0;
    check({tag, "_req"}, {30'd0, dmem_req_o, dmem_we_o}, 32'h2);
    check({tag, "_addr"}, dmem_addr_o, {addr[31:2], 2'b00});
    check({tag, "_be"}, {28'd0, dmem_be_o}, {28'd0, be});
    dmem_gnt_i = 1'b1;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'h80FF7F01;
    step();
    dmem_gnt_i = 1'b0;
    check({tag, "_resp"}, {30'd0, valid_o, stall_o}, 32'h1);
    step();
    dmem_rvalid_i = 1'b0;
    check({tag, "_v"}, {30'd0, valid_o, stall_o}, 32'h2);
    check({tag, "_data"}, wb_data_o, exp);
    check({tag, "_rd"}, {26'd0, rf_w_en_o, rd_addr_o}, {26'd0, 1'b1, 5'd9});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

  initial begin
    step();
    step();
    check("rst_out", {27'd0, stall_o, dmem_req_o, valid_o,
                      rf_w_en_o, misalign_o}, 32'h0);
    check("rst_wb", wb_data_o, 32'h0);
    reset = 1'b0;
    step();

    issue(32'h0, 32'h1234, 32'h0, 5'd5, 1'b1, 2'b00, 2'b00, 2'b10, 1'b0);
    step();
    valid_i = 1'b0;
    check("alu_v", {30'd0, valid_o, stall_o}, 32'h2);
    check("alu_data", wb_data_o, 32'h1234);
    check("alu_rd", {26'd0, rf_w_en_o, rd_addr_o}, {26'd0, 1'b1, 5'd5});

    issue(32'h100, 32'h1234, 32'h0, 5'd5, 1'b1, 2'b10, 2'b00, 2'b10, 1'b0);
    step();
    check("pc4_data", wb_data_o, 32'h104);
    check("pc4_stall", {31'd0, stall_o}, 32'h0);

    issue(32'h0, 32'h55, 32'h0, 5'd0, 1'b1, 2'b00, 2'b11, 2'b10, 1'b0);
    step();
    valid_i = 1'b0;
    check("rd0", {30'd0, valid_o, rf_w_en_o}, 32'h2);
    step();
    check("pulse", {30'd0, valid_o, rf_w_en_o}, 32'h0);

    issue(32'h0, 32'h1003, 32'hAABBCCDD, 5'd3, 1'b0, 2'b00,
          2'b10, 2'b00, 1'b0);
    step();
    valid_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      check("st_ctl", {29'd0, stall_o, dmem_req_o, dmem_we_o}, 32'h7);
      check("st_addr", dmem_addr_o, 32'h1000);
      check("st_be", {28'd0, dmem_be_o}, 32'h8);
      check("st_wdata", dmem_wdata_o, 32'hDDDDDDDD);
      check("st_wait", {31'd0, valid_o}, 32'h0);
      if (c == 1) dmem_gnt_i = 1'b1;
      step();
    end
    dmem_gnt_i = 1'b0;
    check("st_done", {28'd0, valid_o, rf_w_en_o, stall_o, dmem_req_o},
          32'h8);

    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'hDEADBEEF;
    step();
    dmem_rvalid_i = 1'b0;
    check("idle_rvalid", {30'd0, valid_o, stall_o}, 32'h0);

    load("lb", 32'h3003, 2'b00, 1'b0, 4'b1000, 32'hFFFFFF80);
    load("lhu", 32'h3002, 2'b01, 1'b1, 4'b1100, 32'h000080FF);
    load("lw", 32'h3000, 2'b10, 1'b0, 4'b1111, 32'h80FF7F01);

    issue(32'h0, 32'h77, 32'h0, 5'd4, 1'b1, 2'b00, 2'b00, 2'b10, 1'b0);
    step();
    valid_i = 1'b0;
    check("b2b_v", {31'd0, valid_o}, 32'h1);
    check("b2b_data", wb_data_o, 32'h77);
    check("b2b_rd", {27'd0, rd_addr_o}, 32'h4);

    issue(32'h0, 32'h2002, 32'h0, 5'd7, 1'b1, 2'b01, 2'b01, 2'b10, 1'b0);
    check("mis_noreq", {31'd0, dmem_req_o}, 32'h0);
    step();
    valid_i = 1'b0;
    check("mis_flags", {27'd0, valid_o, misalign_o, rf_w_en_o,
                        stall_o, dmem_req_o}, 32'h18);
    check("mis_wb", wb_data_o, 32'h0);

    issue(32'h0, 32'h2001, 32'h0, 5'd7, 1'b1, 2'b01, 2'b01, 2'b01, 1'b0);
    step();
    valid_i = 1'b0;
    check("mis_half", {29'd0, valid_o, misalign_o, stall_o}, 32'h6);

    issue(32'h0, 32'h3000, 32'h0, 5'd9, 1'b1, 2'b01, 2'b01, 2'b10, 1'b0);
    step();
    valid_i = 1'b0;
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    check("rr_instate", {31'd0, stall_o}, 32'h1);
    reset = 1'b1;
    #1;
    check("rr_out", {27'd0, stall_o, dmem_req_o, valid_o,
                     rf_w_en_o, misalign_o}, 32'h0);
    check("rr_wb", {wb_data_o[26:0], rd_addr_o}, 32'h0);
    reset = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'h80FF7F01;
    step();
    dmem_rvalid_i = 1'b0;
    check("rr_late", {29'd0, valid_o, stall_o, dmem_req_o}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
